complex_alu: RTL and testbench
==============================

Name: complex_alu

Overview:
- Execute stage directly downstream of the 64x8 data memory.
- Consumes two operands read from memory and performs complex add, subtract or multiply on the 2-bit opcode.
- Returns the result with a write strobe and destination address that drive the memory's in_data, write and write_address inputs.
- Operand format: upper nibble is the real part and lower nibble is the imaginary part, each 4-bit two's complement (e.g. 8'b1101_0010 = -3+2i).

Parameters:
- DATA_W, 8, operand/result width; must be even; each half is one component.
- ADDR_W, 6, destination address width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  launch request; accepted only while busy=0
- opcode  input  2  00 add, 01 sub, 10 mul, 11 illegal
- dest_addr  input  ADDR_W  write-back address, latched with start
- op_a  input  DATA_W  operand A (memory out_data1)
- op_b  input  DATA_W  operand B (memory out_data2)
- busy  output  1  high from the accepting edge until done
- done  output  1  one-cycle completion pulse
- result  output  DATA_W  packed complex result; held until next done
- wr_en  output  1  write strobe to memory; coincident with done, never for illegal opcode
- wr_addr  output  ADDR_W  latched dest_addr; valid with wr_en
- ovf  output  1  any component of the result exceeded 4-bit signed range; valid with done, held
- err  output  1  illegal opcode flag; valid with done, held

Behaviour:
- Reset (async, any time, including mid-multiply): state IDLE. busy, done, wr_en, ovf and err are 0. result and wr_addr are 0. Accumulators are cleared. No write is issued.
- FSM states: IDLE, ADDSUB, MUL0, MUL1, MUL2, MUL3, DONE.
- IDLE:
  - If start=1, latch op_a, op_b, opcode and dest_addr.
  - Set busy=1.
  - Next state: ADDSUB for 00/01, MUL0 for 10, DONE (err path) for 11.
- ADDSUB: compute re = ar ± br and im = ai ± bi at 5 bits; next state DONE. Latency start→done = 2 cycles.
- MUL0..MUL3: one shared signed 4x4 product per cycle, accumulated into 9-bit signed accumulators:
  - MUL0: acc_re += ar*br
  - MUL1: acc_re -= ai*bi
  - MUL2: acc_im += ar*bi
  - MUL3: acc_im += ai*br
  - Next state DONE. Latency start→done = 5 cycles.
- DONE:
  - Pulse done=1 for one cycle and register result, ovf and err.
  - wr_en = !err.
  - busy drops to 0 in the same cycle; return to IDLE.
  - Next start is accepted the following cycle at the earliest.
- start while busy=1 is ignored; no queueing.
- Operand changes after acceptance have no effect.
- Width rule (default): each component is wrapped to its low 4 bits. ovf=1 if any full-width component is outside -8..7.
- Illegal opcode: result=0, err=1, ovf=0, wr_en=0, done still pulses.
- Back-to-back operations to the same dest_addr are legal; each write is independent.

Optional Feature:
- COMPLEX_SAT_EN
  - Defined: each out-of-range component is clamped to +7 or -8 instead of wrapped; ovf still reports the clamp.
  - Undefined: wrap behaviour as above. Timing and handshake are identical in both builds.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_ILL=2'b11
  - FSM state encoding
  - component width constant CW=DATA_W/2
  - helper functions for packing and unpacking re/im nibbles
- One sub-module, cplx_narrow: a combinational full-width→4-bit component narrower that outputs the narrowed value and an overflow bit. It is instantiated twice (re, im) and honours COMPLEX_SAT_EN.

Test Plan:
- Reset mid-operation: assert rst during MUL2 → busy=0, done never pulses, wr_en stays 0; a fresh start after release works normally.
- Add: op_a=8'h31 (3+1i), op_b=8'h23 (2+3i), op 00, dest 2 → done 2 cycles after start, result=8'h54, wr_en=1, wr_addr=2, ovf=0.
- Sub: op_a=8'hBE (-5-2i), op_b=8'h23, op 01 → result=8'h9B (-7-5i), ovf=0.
- Mul:
  - op_a=8'h22 (2+2i), op_b=8'h21 (2+1i) → result=8'h26 after 5 cycles.
  - op_a=8'hD2 (-3+2i), op_b=8'hE1 (-2+1i) → result=8'h49 (4-7i).
- Overflow: op_a=8'h70, op_b=8'h10, op 00 →
  - default build: result=8'h80, ovf=1
  - COMPLEX_SAT_EN build: result=8'h70, ovf=1
- Illegal opcode and busy handling:
  - op 11 → done pulses, err=1, wr_en=0.
  - start held high throughout a multiply → exactly one operation, busy continuous until done.

Source files
------------

// File: rtl/complex_alu_pkg.sv
// Shared types and helpers for the complex ALU execute stage.
// Each operand packs the real part in the upper nibble and the imaginary part in the lower nibble.
package complex_alu_pkg;

    localparam int CPLX_W = 8;
    localparam int CW     = CPLX_W / 2;
    localparam int AW     = 2 * CW + 1;   // accumulator width: holds a sum of two CWxCW products

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDSUB,
        S_MUL0,
        S_MUL1,
        S_MUL2,
        S_MUL3,
        S_DONE
    } state_t;

    function automatic logic signed [CW-1:0] re_of(input logic [2*CW-1:0] v);
        return v[2*CW-1:CW];
    endfunction

    function automatic logic signed [CW-1:0] im_of(input logic [2*CW-1:0] v);
        return v[CW-1:0];
    endfunction

    function automatic logic [2*CW-1:0] pack_cplx(input logic [CW-1:0] re, input logic [CW-1:0] im);
        return {re, im};
    endfunction

endpackage

// File: rtl/cplx_narrow.sv
// Narrows one full-width signed component to CW bits and flags out-of-range values.
// COMPLEX_SAT_EN selects clamping to the signed limits instead of two's-complement wrap.
module cplx_narrow
    import complex_alu_pkg::*;
#(
    parameter int IW = AW
) (
    input  logic signed [IW-1:0] full,
    output logic [CW-1:0]        narrow,
    output logic                 ovf
);

    localparam int MAXV = (1 << (CW - 1)) - 1;
    localparam int MINV = -(1 << (CW - 1));

    logic hi;
    logic lo;

    assign hi  = int'(full) > MAXV;
    assign lo  = int'(full) < MINV;
    assign ovf = hi | lo;

`ifdef COMPLEX_SAT_EN
    assign narrow = hi ? CW'(MAXV) : (lo ? CW'(MINV) : full[CW-1:0]);
`else
    assign narrow = full[CW-1:0];
`endif

endmodule

// File: rtl/complex_alu.sv
// Complex add/sub/multiply execute stage feeding the data memory's write port.
// Multiply shares one signed CWxCW multiplier over four cycles; define COMPLEX_SAT_EN for saturating results.
module complex_alu
    import complex_alu_pkg::*;
#(
    parameter int DATA_W = 8,   // must equal 2*CW
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        opcode,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              ovf,
    output logic              err
);

    state_t state, state_nxt;

    logic [DATA_W-1:0]      a_q, b_q;
    logic [1:0]             op_q;
    logic [ADDR_W-1:0]      dest_q;
    logic signed [AW-1:0]   acc_re, acc_im;
    logic signed [CW-1:0]   mul_x, mul_y;
    logic signed [2*CW-1:0] prod;
    logic [CW-1:0]          re_n, im_n;
    logic                   ovf_re, ovf_im;
    logic [DATA_W-1:0]      result_q, result_live;
    logic                   ovf_q, err_q, ovf_live;
    logic                   is_ill, in_done;

    // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (opcode)
                        OP_ADD, OP_SUB: state_nxt = S_ADDSUB;
                        OP_MUL:         state_nxt = S_MUL0;
                        default:        state_nxt = S_DONE;
                    endcase
                end
            end
            S_ADDSUB: state_nxt = S_DONE;
            S_MUL0:   state_nxt = S_MUL1;
            S_MUL1:   state_nxt = S_MUL2;
            S_MUL2:   state_nxt = S_MUL3;
            S_MUL3:   state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Operand steering for the single shared multiplier.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state)
            S_MUL0: begin mul_x = re_of(a_q); mul_y = re_of(b_q); end
            S_MUL1: begin mul_x = im_of(a_q); mul_y = im_of(b_q); end
            S_MUL2: begin mul_x = re_of(a_q); mul_y = im_of(b_q); end
            S_MUL3: begin mul_x = im_of(a_q); mul_y = re_of(b_q); end
            default: ;
        endcase
    end

    assign prod = mul_x * mul_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            dest_q   <= '0;
            acc_re   <= '0;
            acc_im   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q    <= op_a;
                        b_q    <= op_b;
                        op_q   <= opcode;
                        dest_q <= dest_addr;
                        acc_re <= '0;
                        acc_im <= '0;
                    end
                end
                S_ADDSUB: begin
                    if (op_q == OP_SUB) begin
                        acc_re <= AW'(re_of(a_q)) - AW'(re_of(b_q));
                        acc_im <= AW'(im_of(a_q)) - AW'(im_of(b_q));
                    end else begin
                        acc_re <= AW'(re_of(a_q)) + AW'(re_of(b_q));
                        acc_im <= AW'(im_of(a_q)) + AW'(im_of(b_q));
                    end
                end
                S_MUL0:  acc_re <= acc_re + AW'(prod);
                S_MUL1:  acc_re <= acc_re - AW'(prod);
                S_MUL2,
                S_MUL3:  acc_im <= acc_im + AW'(prod);
                S_DONE: begin
                    result_q <= result_live;
                    ovf_q    <= ovf_live;
                    err_q    <= is_ill;
                end
                default: ;
            endcase
        end
    end

    cplx_narrow #(.IW(AW)) u_narrow_re (.full(acc_re), .narrow(re_n), .ovf(ovf_re));
    cplx_narrow #(.IW(AW)) u_narrow_im (.full(acc_im), .narrow(im_n), .ovf(ovf_im));

    assign is_ill      = (op_q == OP_ILL);
    assign in_done     = (state == S_DONE);
    assign result_live = is_ill ? '0 : pack_cplx(re_n, im_n);
    assign ovf_live    = !is_ill && (ovf_re || ovf_im);

    // Live values are presented during DONE and captured there so they hold until the next completion.
    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign done    = in_done;
    assign wr_en   = in_done && !is_ill;
    assign wr_addr = dest_q;
    assign result  = in_done ? result_live : result_q;
    assign ovf     = in_done ? ovf_live    : ovf_q;
    assign err     = in_done ? is_ill      : err_q;

endmodule

// File: tb/tb_complex_alu.sv
// Self-checking bench for complex_alu: directed cases plus randomized operations against
// an integer-arithmetic reference model of complex add, subtract and multiply.
module tb_complex_alu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] opcode = 2'b00;
    logic [5:0] dest_addr = '0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       busy, done, wr_en, ovf, err;
    logic [7:0] result;
    logic [5:0] wr_addr;

    int tests = 0;
    int fails = 0;

    complex_alu #(.DATA_W(8), .ADDR_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .dest_addr (dest_addr),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Fit an unbounded component into 4-bit signed range, flagging overflow.
    function automatic int fit(input int v, output logic o);
        o = (v > 7) || (v < -8);
`ifdef COMPLEX_SAT_EN
        if (v > 7)  return 7;
        if (v < -8) return -8;
`endif
        return v;
    endfunction

    function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic o, output logic e,
                                  output int lat);
        int ar, ai, br, bi, re, im;
        logic o_re, o_im;
        ar = int'($signed(a[7:4]));
        ai = int'($signed(a[3:0]));
        br = int'($signed(b[7:4]));
        bi = int'($signed(b[3:0]));
        re = 0;
        im = 0;
        e  = 1'b0;
        case (op)
            2'b00:   begin re = ar + br; im = ai + bi; lat = 2; end
            2'b01:   begin re = ar - br; im = ai - bi; lat = 2; end
            2'b10:   begin re = ar * br - ai * bi; im = ar * bi + ai * br; lat = 5; end
            default: begin e = 1'b1; lat = 1; end
        endcase
        re = fit(re, o_re);
        im = fit(im, o_im);
        o  = o_re | o_im;
        r  = {4'(re), 4'(im)};
    endfunction

    // Launch one operation from a negedge and wait (bounded) for completion.
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [5:0] dest, input bit hold,
                          output int lat, output logic [7:0] r, output logic o,
                          output logic e, output logic w, output logic [5:0] wa,
                          output bit busy_ok, output bit held_ok);
        int cyc;
        cyc     = 0;
        lat     = -1;
        busy_ok = 1'b1;
        r = 'x; o = 1'bx; e = 1'bx; w = 1'bx; wa = 'x;
        opcode = op; op_a = a; op_b = b; dest_addr = dest; start = 1'b1;
        while (lat < 0 && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            op_a = 8'($urandom); op_b = 8'($urandom);
            opcode = 2'($urandom); dest_addr = 6'($urandom);
            if (done) begin
                lat = cyc; r = result; o = ovf; e = err; w = wr_en; wa = wr_addr;
                if (busy) busy_ok = 1'b0;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        start = 1'b0;
        if (lat >= 0) begin
            @(negedge clk);
            held_ok = !done && !busy && !wr_en && (result === r) && (ovf === o) && (err === e);
        end else begin
            held_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, wr_en, ovf, err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got busy/done/wr_en/ovf/err=%b want 00000", {busy, done, wr_en, ovf, err});
        end
        tests++;
        if ({result, wr_addr} !== 14'h0) begin
            fails++;
            $display("FAIL reset_data: got result=%h wr_addr=%0d want 0/0", result, wr_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [7:0] a [5] = '{8'h31, 8'hBE, 8'h22, 8'hD2, 8'h70};
        logic [7:0] b [5] = '{8'h23, 8'h23, 8'h21, 8'hE1, 8'h10};
        logic [1:0] op[5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
        int         el[5] = '{2, 2, 5, 5, 2};
`ifdef COMPLEX_SAT_EN
        logic [7:0] er[5] = '{8'h54, 8'h9B, 8'h26, 8'h49, 8'h70};
`else
        logic [7:0] er[5] = '{8'h54, 8'h9B, 8'h26, 8'h49, 8'h80};
`endif
        logic       eo[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat; logic [7:0] r; logic o, e, w; logic [5:0] wa; bit bok, hok;
        for (int i = 0; i < 5; i++) begin
            run_op(op[i], a[i], b[i], 6'd2, 1'b0, lat, r, o, e, w, wa, bok, hok);
            tests++;
            if (lat !== el[i]) begin
                fails++;
                $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, el[i]);
            end
            tests++;
            if ({r, o, e, w, wa} !== {er[i], eo[i], 1'b0, 1'b1, 6'd2}) begin
                fails++;
                $display("FAIL directed%0d_result: got r=%h ovf=%b err=%b wr=%b addr=%0d want r=%h ovf=%b err=0 wr=1 addr=2",
                         i, r, o, e, w, wa, er[i], eo[i]);
            end
            tests++;
            if (!(bok && hok)) begin
                fails++;
                $display("FAIL directed%0d_handshake: got busy_ok=%b held_ok=%b want 1/1", i, bok, hok);
            end
        end
    endtask

    task automatic test_illegal();
        int lat; logic [7:0] r; logic o, e, w; logic [5:0] wa; bit bok, hok;
        run_op(2'b11, 8'h55, 8'h33, 6'd7, 1'b0, lat, r, o, e, w, wa, bok, hok);
        tests++;
        if (lat !== 1) begin
            fails++;
            $display("FAIL illegal_latency: got %0d want 1", lat);
        end
        tests++;
        if ({r, o, e, w} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL illegal_flags: got r=%h ovf=%b err=%b wr=%b want 00/0/1/0", r, o, e, w);
        end
        tests++;
        if (!hok) begin
            fails++;
            $display("FAIL illegal_hold: got held_ok=%b want 1", hok);
        end
    endtask

    task automatic test_busy_hold();
        int lat; logic [7:0] r; logic o, e, w; logic [5:0] wa; bit bok, hok;
        run_op(2'b10, 8'hD2, 8'hE1, 6'd33, 1'b1, lat, r, o, e, w, wa, bok, hok);
        tests++;
        if (lat !== 5 || r !== 8'h49 || wa !== 6'd33) begin
            fails++;
            $display("FAIL busy_hold_result: got lat=%0d r=%h addr=%0d want 5/49/33", lat, r, wa);
        end
        tests++;
        if (!(bok && hok)) begin
            fails++;
            $display("FAIL busy_hold_single: got busy_ok=%b held_ok=%b want 1/1", bok, hok);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int lat; logic [7:0] r; logic o, e, w; logic [5:0] wa; bit bok, hok;
        seen = 1'b0;
        opcode = 2'b10; op_a = 8'h22; op_b = 8'h21; dest_addr = 6'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, wr_en, result} !== 11'h0) begin
            fails++;
            $display("FAIL reset_mid_async: got busy=%b done=%b wr=%b r=%h want all 0", busy, done, wr_en, result);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || wr_en || busy) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_quiet: got activity=%b want 0", seen);
        end
        run_op(2'b10, 8'h22, 8'h21, 6'd5, 1'b0, lat, r, o, e, w, wa, bok, hok);
        tests++;
        if (lat !== 5 || r !== 8'h26 || w !== 1'b1 || wa !== 6'd5) begin
            fails++;
            $display("FAIL reset_mid_fresh: got lat=%0d r=%h wr=%b addr=%0d want 5/26/1/5", lat, r, w, wa);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] r; logic o, e, w; logic [5:0] wa; bit bok, hok;
        logic [7:0] a[2] = '{8'h11, 8'h3F};
        logic [7:0] b[2] = '{8'h12, 8'hF1};
        logic [7:0] er[2] = '{8'h23, 8'h20};
        for (int i = 0; i < 2; i++) begin
            run_op(2'b00, a[i], b[i], 6'd9, 1'b0, lat, r, o, e, w, wa, bok, hok);
            tests++;
            if ({r, w, wa} !== {er[i], 1'b1, 6'd9} || lat !== 2) begin
                fails++;
                $display("FAIL back_to_back%0d: got r=%h wr=%b addr=%0d lat=%0d want %h/1/9/2", i, r, w, wa, lat, er[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, elat; logic [7:0] r, er; logic o, e, w, eo, ee; logic [5:0] wa; bit bok, hok;
        logic [1:0] op; logic [7:0] a, b; logic [5:0] d;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom); a = 8'($urandom); b = 8'($urandom); d = 6'($urandom);
            model(op, a, b, er, eo, ee, elat);
            run_op(op, a, b, d, 1'($urandom), lat, r, o, e, w, wa, bok, hok);
            tests++;
            if (lat !== elat || {r, o, e, w, wa} !== {er, eo, ee, !ee, d} || !bok || !hok) begin
                fails++;
                $display("FAIL random%0d op=%0d a=%h b=%h: got lat=%0d r=%h ovf=%b err=%b wr=%b addr=%0d busy_ok=%b held_ok=%b want lat=%0d r=%h ovf=%b err=%b wr=%b addr=%0d",
                         i, op, a, b, lat, r, o, e, w, wa, bok, hok, elat, er, eo, ee, !ee, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_busy_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
